// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the hazard/forwarding controller: scoreboard entry layout,
// default widths and the bubble entry pushed on stall or flush.
package pipeline_hazard_unit_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    // Destination field is sized for the widest supported register file;
    // narrower instances zero-extend on issue and compare.
    localparam int SB_DST_W = 8;

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                reg_write;
        logic                is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/pipeline_hazard_unit_hazard_match.sv
// Scans the in-flight scoreboard for the youngest writer of one source
// register and reports whether its result can already be forwarded.
module hazard_match
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 1,
    parameter int IDX_W      = $clog2(STAGES)
) (
    input  sb_entry_t         sb_i [STAGES],
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic              use_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  slot_o,
    output logic              ready_o
);

    logic [SB_DST_W-1:0] src_ext;

    assign src_ext = SB_DST_W'(src_i);

    // Walk oldest to youngest so the lowest matching slot is the one left standing.
    always_comb begin
        hit_o   = 1'b0;
        slot_o  = '0;
        ready_o = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (sb_i[k].valid && sb_i[k].reg_write && (sb_i[k].dst == src_ext)
                && use_i && id_valid_i) begin
                hit_o   = 1'b1;
                slot_o  = IDX_W'(k);
                ready_o = !sb_i[k].is_load || (k >= LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller at the decode/execute boundary: tracks
// in-flight writers, forwards operands, inserts load-use stalls, counts events.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [ADDR_W-1:0]        id_src1,
    input  logic [ADDR_W-1:0]        id_src2,
    input  logic                     id_use1,
    input  logic                     id_use2,
    input  logic [ADDR_W-1:0]        id_dst,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     flush,
    input  logic [DATA_W*STAGES-1:0] stage_data,
    output logic                     stall,
    output logic                     fwd_en1,
    output logic                     fwd_en2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [CNT_W-1:0]         stall_count,
    output logic [CNT_W-1:0]         fwd_count
);

    localparam int               IDX_W   = $clog2(STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_entry_t sb_q [STAGES];
    sb_entry_t sb_d [STAGES];

    logic             hit1, hit2, rdy1, rdy2;
    logic [IDX_W-1:0] slot1, slot2;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [1:0]       fwd_inc;
    logic [CNT_W:0]   fwd_sum;

    hazard_match #(
        .ADDR_W    (ADDR_W),
        .STAGES    (STAGES),
        .LOAD_READY(LOAD_READY),
        .IDX_W     (IDX_W)
    ) u_match1 (
        .sb_i      (sb_q),
        .id_valid_i(id_valid),
        .src_i     (id_src1),
        .use_i     (id_use1),
        .hit_o     (hit1),
        .slot_o    (slot1),
        .ready_o   (rdy1)
    );

    hazard_match #(
        .ADDR_W    (ADDR_W),
        .STAGES    (STAGES),
        .LOAD_READY(LOAD_READY),
        .IDX_W     (IDX_W)
    ) u_match2 (
        .sb_i      (sb_q),
        .id_valid_i(id_valid),
        .src_i     (id_src2),
        .use_i     (id_use2),
        .hit_o     (hit2),
        .slot_o    (slot2),
        .ready_o   (rdy2)
    );

    // Flush squashes the decode instruction, so waiting on its operands is moot.
    assign stall = id_valid && !flush && ((hit1 && !rdy1) || (hit2 && !rdy2));

    assign fwd_en1   = hit1 && rdy1 && !stall;
    assign fwd_en2   = hit2 && rdy2 && !stall;
    assign fwd_data1 = fwd_en1 ? stage_data[int'(slot1)*DATA_W +: DATA_W] : '0;
    assign fwd_data2 = fwd_en2 ? stage_data[int'(slot2)*DATA_W +: DATA_W] : '0;

    // The pipeline behind decode never holds, so the scoreboard shifts every cycle.
    always_comb begin
        sb_d[0]           = SB_BUBBLE;
        sb_d[0].valid     = id_valid && !stall && !flush;
        sb_d[0].dst       = SB_DST_W'(id_dst);
        sb_d[0].reg_write = id_reg_write;
        sb_d[0].is_load   = id_mem_read;
        for (int k = 1; k < STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sb_q[k] <= SB_BUBBLE;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                sb_q[k] <= sb_d[k];
            end
        end
    end

    assign fwd_inc = {1'b0, fwd_en1} + {1'b0, fwd_en2};
    assign fwd_sum = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_inc);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        fwd_cnt_d = fwd_sum[CNT_W-1:0];
        if (fwd_sum > {1'b0, CNT_MAX}) begin
            fwd_cnt_d = CNT_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: default instance plus a CNT_W=2
// instance sharing stimulus to observe counter saturation.
module tb_pipeline_hazard_unit;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int STAGES = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     id_valid;
    logic [ADDR_W-1:0]        id_src1, id_src2, id_dst;
    logic                     id_use1, id_use2, id_reg_write, id_mem_read;
    logic                     flush;
    logic [DATA_W*STAGES-1:0] stage_data;

    logic              stall, fwd_en1, fwd_en2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;
    logic [15:0]       stall_count, fwd_count;

    logic              stall_s, fwd_en1_s, fwd_en2_s;
    logic [DATA_W-1:0] fwd_data1_s, fwd_data2_s;
    logic [1:0]        stall_count_s, fwd_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stage_data(stage_data),
        .stall(stall), .fwd_en1(fwd_en1), .fwd_en2(fwd_en2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .stall_count(stall_count), .fwd_count(fwd_count)
    );

    pipeline_hazard_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stage_data(stage_data),
        .stall(stall_s), .fwd_en1(fwd_en1_s), .fwd_en2(fwd_en2_s),
        .fwd_data1(fwd_data1_s), .fwd_data2(fwd_data2_s),
        .stall_count(stall_count_s), .fwd_count(fwd_count_s)
    );

    task automatic idle();
        id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
        id_dst = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
        stage_data = '0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] dst, input logic wr, input logic ld);
        id_valid = 1'b1; id_dst = dst; id_reg_write = wr; id_mem_read = ld;
    endtask

    task automatic set_slot(input int k, input logic [DATA_W-1:0] v);
        stage_data[k*DATA_W +: DATA_W] = v;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow one unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        step(); step();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if ({fwd_en1, fwd_en2} !== 2'b00) begin errors++; $display("FAIL reset_fwd_en got %b exp 00", {fwd_en1, fwd_en2}); end
        checks++; if (fwd_data1 !== 16'h0) begin errors++; $display("FAIL reset_fwd_data1 got %h exp 0000", fwd_data1); end
        checks++; if (stall_count !== 16'd0 || fwd_count !== 16'd0) begin errors++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_count, fwd_count); end
    endtask

    task automatic test_forward_alu();
        do_reset();
        issue(3'd1, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b0 || fwd_en1 !== 1'b0) begin errors++;
            $display("FAIL alu_issue got stall=%b en1=%b exp 0/0", stall, fwd_en1); end
        step();
        issue(3'd4, 1'b1, 1'b0);
        id_src1 = 3'd1; id_use1 = 1'b1;
        id_src2 = 3'd1; id_use2 = 1'b0;
        set_slot(0, 16'h0025);
        #1;
        checks++; if (fwd_en1 !== 1'b1 || fwd_data1 !== 16'h0025) begin errors++;
            $display("FAIL alu_fwd1 got en=%b data=%h exp 1/0025", fwd_en1, fwd_data1); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall); end
        checks++; if (fwd_en2 !== 1'b0 || fwd_data2 !== 16'h0) begin errors++;
            $display("FAIL alu_unused_src2 got en=%b data=%h exp 0/0000", fwd_en2, fwd_data2); end
        step();
        idle();
        #1;
        checks++; if (fwd_count !== 16'd1 || stall_count !== 16'd0) begin errors++;
            $display("FAIL alu_counts got fwd=%0d stall=%0d exp 1/0", fwd_count, stall_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(3'd2, 1'b1, 1'b1);
        step();
        // Consumer also writes r2: a non-bubble slot 0 would steal the forward.
        issue(3'd2, 1'b1, 1'b0);
        id_src1 = 3'd2; id_use1 = 1'b1;
        #1;
        checks++; if (stall !== 1'b1 || fwd_en1 !== 1'b0 || fwd_data1 !== 16'h0) begin errors++;
            $display("FAIL lu_stall got stall=%b en=%b data=%h exp 1/0/0000", stall, fwd_en1, fwd_data1); end
        step();
        set_slot(0, 16'h1111);
        set_slot(1, 16'h00A0);
        #1;
        checks++; if (stall !== 1'b0 || fwd_en1 !== 1'b1 || fwd_data1 !== 16'h00A0) begin errors++;
            $display("FAIL lu_fwd_slot1 got stall=%b en=%b data=%h exp 0/1/00a0", stall, fwd_en1, fwd_data1); end
        checks++; if (stall_count !== 16'd1) begin errors++;
            $display("FAIL lu_stall_count got %0d exp 1", stall_count); end
        step();
        idle();
        #1;
        checks++; if (stall_count !== 16'd1 || fwd_count !== 16'd1) begin errors++;
            $display("FAIL lu_counts got stall=%0d fwd=%0d exp 1/1", stall_count, fwd_count); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(3'd2, 1'b1, 1'b1);
        step();
        issue(3'd2, 1'b1, 1'b0);
        id_src1 = 3'd2; id_use1 = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || fwd_en1 !== 1'b0) begin errors++;
            $display("FAIL flush_stall got stall=%b en=%b exp 0/0", stall, fwd_en1); end
        step();
        flush = 1'b0;
        set_slot(0, 16'h5555);
        set_slot(1, 16'h00A0);
        #1;
        checks++; if (stall !== 1'b0 || fwd_data1 !== 16'h00A0) begin errors++;
            $display("FAIL flush_bubble got stall=%b data=%h exp 0/00a0", stall, fwd_data1); end
        checks++; if (stall_count !== 16'd0) begin errors++;
            $display("FAIL flush_stall_count got %0d exp 0", stall_count); end
        idle();
    endtask

    task automatic test_youngest_and_retire();
        do_reset();
        issue(3'd3, 1'b1, 1'b0);
        step();
        issue(3'd6, 1'b1, 1'b0);
        step();
        issue(3'd3, 1'b1, 1'b0);
        step();
        // slot0=r3, slot1=r6, slot2=r3; this cycle's instruction writes nothing.
        issue(3'd0, 1'b0, 1'b0);
        id_src1 = 3'd3; id_use1 = 1'b1;
        id_src2 = 3'd3; id_use2 = 1'b1;
        set_slot(0, 16'h0003); set_slot(1, 16'h0006); set_slot(2, 16'h0009);
        #1;
        checks++; if (fwd_data1 !== 16'h0003 || fwd_data2 !== 16'h0003) begin errors++;
            $display("FAIL youngest got %h/%h exp 0003/0003", fwd_data1, fwd_data2); end
        step();
        // slot1=r3, slot2=r6
        id_src2 = 3'd6;
        set_slot(0, 16'h0000); set_slot(1, 16'h0033); set_slot(2, 16'h0666);
        #1;
        checks++; if (fwd_data1 !== 16'h0033 || fwd_data2 !== 16'h0666 || fwd_en1 !== 1'b1 || fwd_en2 !== 1'b1) begin errors++;
            $display("FAIL two_slots got %h/%h en=%b%b exp 0033/0666 en=11", fwd_data1, fwd_data2, fwd_en1, fwd_en2); end
        step();
        // slot2=r3, r6 retired
        set_slot(2, 16'h0077);
        #1;
        checks++; if (fwd_data1 !== 16'h0077 || fwd_en2 !== 1'b0) begin errors++;
            $display("FAIL oldest_slot got %h en2=%b exp 0077/0", fwd_data1, fwd_en2); end
        step();
        #1;
        checks++; if (fwd_en1 !== 1'b0 || fwd_en2 !== 1'b0 || stall !== 1'b0) begin errors++;
            $display("FAIL retired got en=%b%b stall=%b exp 00/0", fwd_en1, fwd_en2, stall); end
        checks++; if (fwd_count !== 16'd5) begin errors++;
            $display("FAIL retire_fwd_count got %0d exp 5", fwd_count); end
        idle();
    endtask

    task automatic test_saturate_and_async_reset();
        do_reset();
        // LW r1,0(r1) held in decode stalls every other cycle.
        issue(3'd1, 1'b1, 1'b1);
        id_src1 = 3'd1; id_use1 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        #1;
        checks++; if (stall_count !== 16'd5 || stall_count_s !== 2'd3) begin errors++;
            $display("FAIL sat_stall got %0d/%0d exp 5/3", stall_count, stall_count_s); end
        checks++; if (fwd_count !== 16'd4 || fwd_count_s !== 2'd3) begin errors++;
            $display("FAIL sat_fwd got %0d/%0d exp 4/3", fwd_count, fwd_count_s); end
        step();
        #1;
        checks++; if (stall !== 1'b1 || stall_s !== 1'b1) begin errors++;
            $display("FAIL pre_reset_stall got %b/%b exp 1/1", stall, stall_s); end
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || fwd_en1 !== 1'b0 || fwd_data1 !== 16'h0 || stall_s !== 1'b0) begin errors++;
            $display("FAIL mid_reset_outputs got stall=%b en=%b data=%h exp 0/0/0000", stall, fwd_en1, fwd_data1); end
        checks++; if (stall_count !== 16'd0 || fwd_count !== 16'd0 || stall_count_s !== 2'd0 || fwd_count_s !== 2'd0) begin errors++;
            $display("FAIL mid_reset_counters got %0d/%0d/%0d/%0d exp 0", stall_count, fwd_count, stall_count_s, fwd_count_s); end
        step();
        reset = 1'b1;
        idle();
        step();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_forward_alu();
        test_load_use();
        test_flush();
        test_youngest_and_retire();
        test_saturate_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
